// File: rtl/seg_pktgen_pkg.sv
// seg_pktgen_pkg
// Shared types and constants for the seg_packet_gen block: the generator
// state enum, DCMAC segment geometry and the payload mode encodings.
package seg_pktgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int SEG_W     = 128;  // bits per DCMAC segment
    localparam int SEG_WORDS = 8;    // 16-bit payload words per segment

    localparam logic DATA_MODE_SEG = 1'b0;  // per-segment numbering
    localparam logic DATA_MODE_CNT = 1'b1;  // one counter replicated

endpackage

// File: rtl/seg_pktgen_len_seq.sv
// seg_pktgen_len_seq
// Holds the current packet length and steps it through the min/max/step
// sweep. Also derives the beat count of the current packet and the tkeep
// mask of its last beat.
// Ports:
//   clk                       rising-edge clock
//   load                      latch sweep config, cur_len = len_min
//   advance                   step to the next packet's length
//   len_min/len_max/len_step  sweep config (sampled on load only)
//   total_beats               beats in the current packet
//   last_keep                 tkeep for the last beat of the current packet
module seg_pktgen_len_seq #(
    parameter int DW = 512
) (
    input  logic             clk,
    input  logic             load,
    input  logic             advance,
    input  logic [15:0]      len_min,
    input  logic [15:0]      len_max,
    input  logic [15:0]      len_step,
    output logic [15:0]      total_beats,
    output logic [DW/8-1:0]  last_keep
);
    localparam int BYTES = DW / 8;

    logic [15:0] cur_len_q, cur_len_d;
    logic [15:0] min_q, min_d;
    logic [15:0] max_q, max_d;
    logic [15:0] step_q, step_d;
    logic [16:0] next_sum;
    logic [15:0] eff_len;
    logic [15:0] rem;

    always_comb begin
        cur_len_d = cur_len_q;
        min_d     = min_q;
        max_d     = max_q;
        step_d    = step_q;
        // 17-bit sum so a sweep near 64K cannot wrap past len_max
        next_sum  = {1'b0, cur_len_q} + {1'b0, step_q};
        if (load) begin
            min_d     = len_min;
            max_d     = len_max;
            step_d    = len_step;
            cur_len_d = len_min;
        end else if (advance) begin
            if (step_q == 16'd0 || max_q < min_q || next_sum > {1'b0, max_q})
                cur_len_d = min_q;
            else
                cur_len_d = next_sum[15:0];
        end
    end

    // Sweep state carries no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        cur_len_q <= cur_len_d;
        min_q     <= min_d;
        max_q     <= max_d;
        step_q    <= step_d;
    end

    always_comb begin
        eff_len     = (cur_len_q == 16'd0) ? 16'd1 : cur_len_q;
        rem         = eff_len % 16'(BYTES);
        total_beats = (eff_len / 16'(BYTES)) + ((rem != 16'd0) ? 16'd1 : 16'd0);
        for (int i = 0; i < BYTES; i++)
            last_keep[i] = (rem == 16'd0) || (i < int'(rem));
    end

endmodule

// File: rtl/seg_packet_gen.sv
// seg_packet_gen
// AXI4-Stream packet generator for DCMAC bring-up traffic. Emits
// packet_count packets (0 = until stop) with a fixed or sweeping length,
// idle_cycles dead clocks between packets, and a segment-numbered or
// replicated-counter payload.
// Optional feature macro: SEG_PKTGEN_SEQNUM_EN -- when defined, bytes 0..3
// of the first beat of every packet carry pkt_num (little-endian).
// Ports:
//   clk, resetn                     clock, async active-low reset
//   packet_count, len_min/max/step, idle_cycles, initial_value, data_mode
//                                   run config, latched on start
//   start, stop                     run control pulses
//   busy, packets_sent              status
//   axis_out_*                      AXI4-Stream master
module seg_packet_gen
    import seg_pktgen_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      packet_count,
    input  logic [15:0]      len_min,
    input  logic [15:0]      len_max,
    input  logic [15:0]      len_step,
    input  logic [15:0]      idle_cycles,
    input  logic [15:0]      initial_value,
    input  logic             data_mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [31:0]      packets_sent,
    output logic [DW-1:0]    axis_out_tdata,
    output logic [DW/8-1:0]  axis_out_tkeep,
    output logic             axis_out_tlast,
    output logic             axis_out_tvalid,
    input  logic             axis_out_tready
);
    localparam int NSEG = DW / SEG_W;

    state_e      state_q, state_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic        mode_q, mode_d;
    logic [15:0] data0_q, data0_d;
    logic [15:0] beat_q, beat_d;
    logic [31:0] pkt_num_q, pkt_num_d;
    logic [31:0] sent_q, sent_d;
    logic        stop_pend_q, stop_pend_d;
    logic [15:0] gap_q, gap_d;

    logic            load, advance, hs, is_last, stop_any;
    logic [15:0]     total_beats;
    logic [DW/8-1:0] last_keep;
    logic [DW-1:0]   pattern;

    seg_pktgen_len_seq #(.DW(DW)) u_len_seq (
        .clk         (clk),
        .load        (load),
        .advance     (advance),
        .len_min     (len_min),
        .len_max     (len_max),
        .len_step    (len_step),
        .total_beats (total_beats),
        .last_keep   (last_keep)
    );

    always_comb begin
        state_d     = state_q;
        pkt_cnt_d   = pkt_cnt_q;
        idle_d      = idle_q;
        mode_d      = mode_q;
        data0_d     = data0_q;
        beat_d      = beat_q;
        pkt_num_d   = pkt_num_q;
        sent_d      = sent_q;
        stop_pend_d = stop_pend_q;
        gap_d       = gap_q;
        load        = 1'b0;
        advance     = 1'b0;
        hs          = (state_q == SEND) && axis_out_tready;
        is_last     = (beat_q == total_beats);
        // A stop arriving on the boundary cycle itself also ends the run there.
        stop_any    = stop_pend_q | stop;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND;
                    pkt_cnt_d   = packet_count;
                    idle_d      = idle_cycles;
                    mode_d      = data_mode;
                    data0_d     = initial_value;
                    beat_d      = 16'd1;
                    pkt_num_d   = 32'd1;
                    sent_d      = 32'd0;
                    stop_pend_d = 1'b0;
                    load        = 1'b1;
                end
            end
            SEND: begin
                stop_pend_d = stop_any;
                if (hs) begin
                    beat_d  = beat_q + 16'd1;
                    data0_d = data0_q + ((mode_q == DATA_MODE_CNT) ? 16'd1 : 16'(NSEG));
                    if (is_last) begin
                        sent_d = sent_q + 32'd1;
                        beat_d = 16'd1;
                        if ((pkt_cnt_q != 32'd0 && pkt_num_q == pkt_cnt_q) || stop_any) begin
                            state_d = IDLE;
                        end else begin
                            pkt_num_d = pkt_num_q + 32'd1;
                            advance   = 1'b1;
                            if (idle_q != 16'd0) begin
                                state_d = GAP;
                                gap_d   = idle_q;
                            end
                        end
                    end
                end
            end
            GAP: begin
                stop_pend_d = stop_any;
                if (stop_any)
                    state_d = IDLE;
                else if (gap_q <= 16'd1)
                    state_d = SEND;
                else
                    gap_d = gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pkt_cnt_q   <= 32'd0;
            idle_q      <= 16'd0;
            beat_q      <= 16'd1;
            pkt_num_q   <= 32'd0;
            sent_q      <= 32'd0;
            stop_pend_q <= 1'b0;
            gap_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            idle_q      <= idle_d;
            beat_q      <= beat_d;
            pkt_num_q   <= pkt_num_d;
            sent_q      <= sent_d;
            stop_pend_q <= stop_pend_d;
            gap_q       <= gap_d;
        end
    end

    // Payload state is only observed while tvalid, so it needs no reset.
    always_ff @(posedge clk) begin
        mode_q  <= mode_d;
        data0_q <= data0_d;
    end

    always_comb begin
        pattern = '0;
        for (int s = 0; s < NSEG; s++)
            for (int w = 0; w < SEG_WORDS; w++)
                pattern[s*SEG_W + w*16 +: 16] =
                    (mode_q == DATA_MODE_CNT) ? data0_q : data0_q + 16'(s);
`ifdef SEG_PKTGEN_SEQNUM_EN
        if (beat_q == 16'd1)
            pattern[31:0] = pkt_num_q;
`endif
    end

    // Outputs are forced to their idle values outside SEND so an async
    // reset drops the stream in the same cycle.
    always_comb begin
        axis_out_tvalid = (state_q == SEND);
        axis_out_tdata  = axis_out_tvalid ? pattern : '0;
        axis_out_tlast  = axis_out_tvalid && is_last;
        axis_out_tkeep  = axis_out_tlast ? last_keep : '1;
        busy            = start | (state_q != IDLE);
        packets_sent    = sent_q;
    end

endmodule

// File: tb/tb_seg_packet_gen.sv
module tb_seg_packet_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] packet_count = '0;
    logic [15:0] len_min = '0, len_max = '0, len_step = '0;
    logic [15:0] idle_cycles = '0, initial_value = '0;
    logic        data_mode = 1'b0, start = 1'b0, stop = 1'b0, tready = 1'b1;

    logic         busy5, busy2, tlast5, tlast2, tvalid5, tvalid2;
    logic [31:0]  sent5, sent2;
    logic [511:0] tdata5;
    logic [63:0]  tkeep5;
    logic [255:0] tdata2;
    logic [31:0]  tkeep2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [511:0] q5_data[$];
    logic [63:0]  q5_keep[$];
    logic         q5_last[$];
    int           q5_cyc[$];
    logic [255:0] q2_data[$];
    logic [31:0]  q2_keep[$];
    logic         q2_last[$];
    int           q2_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_packet_gen #(.DW(512)) dut (
        .clk(clk), .resetn(resetn), .packet_count(packet_count),
        .len_min(len_min), .len_max(len_max), .len_step(len_step),
        .idle_cycles(idle_cycles), .initial_value(initial_value),
        .data_mode(data_mode), .start(start), .stop(stop),
        .busy(busy5), .packets_sent(sent5),
        .axis_out_tdata(tdata5), .axis_out_tkeep(tkeep5),
        .axis_out_tlast(tlast5), .axis_out_tvalid(tvalid5),
        .axis_out_tready(tready)
    );

    seg_packet_gen #(.DW(256)) dut256 (
        .clk(clk), .resetn(resetn), .packet_count(packet_count),
        .len_min(len_min), .len_max(len_max), .len_step(len_step),
        .idle_cycles(idle_cycles), .initial_value(initial_value),
        .data_mode(data_mode), .start(start), .stop(stop),
        .busy(busy2), .packets_sent(sent2),
        .axis_out_tdata(tdata2), .axis_out_tkeep(tkeep2),
        .axis_out_tlast(tlast2), .axis_out_tvalid(tvalid2),
        .axis_out_tready(tready)
    );

    // Record every handshake; the edge that completes it follows this negedge.
    always @(negedge clk) begin
        if (resetn && tvalid5 && tready) begin
            q5_data.push_back(tdata5); q5_keep.push_back(tkeep5);
            q5_last.push_back(tlast5); q5_cyc.push_back(cyc);
        end
        if (resetn && tvalid2 && tready) begin
            q2_data.push_back(tdata2); q2_keep.push_back(tkeep2);
            q2_last.push_back(tlast2); q2_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        q5_data.delete(); q5_keep.delete(); q5_last.delete(); q5_cyc.delete();
        q2_data.delete(); q2_keep.delete(); q2_last.delete(); q2_cyc.delete();
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; tready = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        clear_q();
    endtask

    task automatic set_cfg(input logic [31:0] cnt, input logic [15:0] lmin,
                           input logic [15:0] lmax, input logic [15:0] lstep,
                           input logic [15:0] idle, input logic [15:0] init,
                           input logic mode);
        packet_count = cnt; len_min = lmin; len_max = lmax; len_step = lstep;
        idle_cycles = idle; initial_value = init; data_mode = mode;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input bit use256, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!(use256 ? busy2 : busy5)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tvalid5 !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid5); end
        total++; if (tlast5 !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", tlast5); end
        total++; if (tkeep5 !== '1) begin bad++; $display("FAIL reset_tkeep got=%h want=all-ones", tkeep5); end
        total++; if (tdata5 !== '0) begin bad++; $display("FAIL reset_tdata got=%h want=0", tdata5); end
        total++; if (busy5 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy5); end
        total++; if (sent5 !== 32'd0) begin bad++; $display("FAIL reset_sent got=%0d want=0", sent5); end
        // stop while idle must not start anything
        stop = 1'b1; @(posedge clk); #1 stop = 1'b0; @(posedge clk); #1;
        total++; if (busy5 !== 1'b0 || tvalid5 !== 1'b0) begin bad++; $display("FAIL idle_stop busy=%b tvalid=%b want=0,0", busy5, tvalid5); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] e;
        bit ok;
        do_reset();
        set_cfg(32'd3, 16'd64, 16'd64, 16'd0, 16'd0, 16'h0000, 1'b0);
        @(posedge clk); #1 start = 1'b1; #1;
        total++; if (busy5 !== 1'b1 || tvalid5 !== 1'b0) begin bad++; $display("FAIL b2b_busy_comb busy=%b tvalid=%b want=1,0", busy5, tvalid5); end
        @(posedge clk); #1 start = 1'b0;
        total++; if (tvalid5 !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", tvalid5); end
        wait_idle(1'b0, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=busy want=idle"); end
        total++; if (q5_data.size() != 3) begin bad++; $display("FAIL b2b_beats got=%0d want=3", q5_data.size()); end
        for (int n = 0; n < q5_data.size() && n < 3; n++) begin
            for (int k = 0; k < 4; k++)
                for (int w = 0; w < 8; w++)
                    e[k*128 + w*16 +: 16] = 16'(4*n + k);
`ifdef SEG_PKTGEN_SEQNUM_EN
            e[31:0] = 32'(n + 1);
`endif
            total++; if (q5_data[n] !== e) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", n, q5_data[n], e); end
            total++; if (q5_last[n] !== 1'b1 || q5_keep[n] !== '1) begin bad++; $display("FAIL b2b_last_keep%0d last=%b keep=%h want=1,all-ones", n, q5_last[n], q5_keep[n]); end
            if (n > 0) begin
                total++; if (q5_cyc[n] - q5_cyc[n-1] != 1) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=1", n, q5_cyc[n] - q5_cyc[n-1]); end
            end
        end
        total++; if (sent5 !== 32'd3) begin bad++; $display("FAIL b2b_sent got=%0d want=3", sent5); end
    endtask

    task automatic test_dw256_gap();
        logic [255:0] e;
        logic [15:0]  w16;
        bit ok;
        do_reset();
        set_cfg(32'd2, 16'd100, 16'd100, 16'd0, 16'd5, 16'h0100, 1'b1);
        pulse_start();
        wait_idle(1'b1, 300, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_timeout got=busy want=idle"); end
        total++; if (q2_data.size() != 8) begin bad++; $display("FAIL gap_beats got=%0d want=8", q2_data.size()); end
        for (int b = 0; b < q2_data.size() && b < 8; b++) begin
            w16 = 16'h0100 + 16'(b);
            e = {16{w16}};
`ifdef SEG_PKTGEN_SEQNUM_EN
            if (b == 0) e[31:0] = 32'd1;
            if (b == 4) e[31:0] = 32'd2;
`endif
            total++; if (q2_data[b] !== e) begin bad++; $display("FAIL gap_data%0d got=%h want=%h", b, q2_data[b], e); end
            total++;
            if ((b % 4) == 3) begin
                if (q2_last[b] !== 1'b1 || q2_keep[b] !== 32'h0000000F) begin bad++; $display("FAIL gap_lastbeat%0d last=%b keep=%h want=1,0000000f", b, q2_last[b], q2_keep[b]); end
            end else begin
                if (q2_last[b] !== 1'b0 || q2_keep[b] !== 32'hFFFFFFFF) begin bad++; $display("FAIL gap_midbeat%0d last=%b keep=%h want=0,ffffffff", b, q2_last[b], q2_keep[b]); end
            end
        end
        if (q2_cyc.size() >= 5) begin
            total++; if (q2_cyc[4] - q2_cyc[3] != 6) begin bad++; $display("FAIL gap_idle got=%0d want=6", q2_cyc[4] - q2_cyc[3]); end
        end
        total++; if (sent2 !== 32'd2) begin bad++; $display("FAIL gap_sent got=%0d want=2", sent2); end
    endtask

    task automatic test_sweep();
        logic [63:0] ek[7];
        logic        el[7];
        bit ok;
        // lengths 60, 95, 130, 60 on a 64-byte bus
        ek = '{64'h0FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h000000007FFFFFFF,
               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000003,
               64'h0FFFFFFFFFFFFFFF};
        el = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        set_cfg(32'd4, 16'd60, 16'd130, 16'd35, 16'd0, 16'h0000, 1'b0);
        pulse_start();
        wait_idle(1'b0, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL sweep_timeout got=busy want=idle"); end
        total++; if (q5_data.size() != 7) begin bad++; $display("FAIL sweep_beats got=%0d want=7", q5_data.size()); end
        for (int b = 0; b < q5_data.size() && b < 7; b++) begin
            total++; if (q5_last[b] !== el[b] || q5_keep[b] !== ek[b]) begin bad++; $display("FAIL sweep_beat%0d last=%b keep=%h want=%b,%h", b, q5_last[b], q5_keep[b], el[b], ek[b]); end
        end
        total++; if (sent5 !== 32'd4) begin bad++; $display("FAIL sweep_sent got=%0d want=4", sent5); end
    endtask

    task automatic test_stop_backpressure();
        int tlast_cnt = 0, beats = 0, in_pkt = 0;
        bit stopped = 1'b0, stall = 1'b0, done = 1'b0;
        logic [511:0] hd;
        logic [63:0]  hk;
        logic         hl;
        do_reset();
        set_cfg(32'd0, 16'd150, 16'd150, 16'd0, 16'd1, 16'h0010, 1'b0);
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            if (stopped && !busy5) begin done = 1'b1; break; end
            if (stall) begin
                total++;
                if (tvalid5 !== 1'b1 || tdata5 !== hd || tkeep5 !== hk || tlast5 !== hl) begin
                    bad++; $display("FAIL stall_hold cyc=%0d valid=%b last=%b keep=%h want=1,%b,%h", cyc, tvalid5, tlast5, tkeep5, hl, hk);
                end
            end
            stop = (tlast_cnt == 6 && in_pkt == 1 && !stopped);
            if (stop) stopped = 1'b1;
            tready = 1'($urandom_range(0, 1));
            stall = tvalid5 && !tready;
            hd = tdata5; hk = tkeep5; hl = tlast5;
            if (tvalid5 && tready) begin
                beats++; in_pkt++;
                if (tlast5) begin tlast_cnt++; in_pkt = 0; end
            end
            @(posedge clk); #1;
        end
        stop = 1'b0; tready = 1'b1;
        total++; if (!done) begin bad++; $display("FAIL stop_timeout got=busy want=idle"); end
        total++; if (sent5 !== 32'd7) begin bad++; $display("FAIL stop_sent got=%0d want=7", sent5); end
        total++; if (tlast_cnt != 7) begin bad++; $display("FAIL stop_tlasts got=%0d want=7", tlast_cnt); end
        total++; if (beats != 21) begin bad++; $display("FAIL stop_beats got=%0d want=21", beats); end
        total++; if (tvalid5 !== 1'b0) begin bad++; $display("FAIL stop_idle_valid got=%b want=0", tvalid5); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] e;
        bit ok;
        do_reset();
        set_cfg(32'd0, 16'd200, 16'd200, 16'd0, 16'd0, 16'h0000, 1'b0);
        tready = 1'b0;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        total++; if (tvalid5 !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b want=1", tvalid5); end
        resetn = 1'b0; #1;
        total++; if (tvalid5 !== 1'b0 || busy5 !== 1'b0) begin bad++; $display("FAIL rstmid_drop valid=%b busy=%b want=0,0", tvalid5, busy5); end
        total++; if (sent5 !== 32'd0 || tlast5 !== 1'b0) begin bad++; $display("FAIL rstmid_state sent=%0d last=%b want=0,0", sent5, tlast5); end
        @(posedge clk); #1 resetn = 1'b1; tready = 1'b1;
        clear_q();
        set_cfg(32'd1, 16'd64, 16'd64, 16'd0, 16'd0, 16'hABCD, 1'b1);
        pulse_start();
        wait_idle(1'b0, 100, ok);
        e = {32{16'hABCD}};
`ifdef SEG_PKTGEN_SEQNUM_EN
        e[31:0] = 32'd1;
`endif
        total++; if (!ok || q5_data.size() != 1) begin bad++; $display("FAIL restart_beats ok=%b got=%0d want=1", ok, q5_data.size()); end
        if (q5_data.size() >= 1) begin
            total++; if (q5_data[0] !== e || q5_last[0] !== 1'b1) begin bad++; $display("FAIL restart_data got=%h last=%b want=%h,1", q5_data[0], q5_last[0], e); end
        end
        total++; if (sent5 !== 32'd1) begin bad++; $display("FAIL restart_sent got=%0d want=1", sent5); end
    endtask

    task automatic test_seqnum();
        logic [31:0] exp_lo[2];
        logic [15:0] exp_w[2];
        bit ok;
`ifdef SEG_PKTGEN_SEQNUM_EN
        exp_lo = '{32'd1, 32'd2};
`else
        exp_lo = '{32'h55555555, 32'h55565556};
`endif
        exp_w = '{16'h5555, 16'h5556};
        do_reset();
        set_cfg(32'd2, 16'd16, 16'd16, 16'd0, 16'd0, 16'h5555, 1'b1);
        pulse_start();
        wait_idle(1'b0, 100, ok);
        total++; if (!ok || q5_data.size() != 2) begin bad++; $display("FAIL seq_beats ok=%b got=%0d want=2", ok, q5_data.size()); end
        for (int n = 0; n < q5_data.size() && n < 2; n++) begin
            total++; if (q5_data[n][31:0] !== exp_lo[n]) begin bad++; $display("FAIL seq_lo%0d got=%h want=%h", n, q5_data[n][31:0], exp_lo[n]); end
            total++; if (q5_data[n][47:32] !== exp_w[n]) begin bad++; $display("FAIL seq_word2_%0d got=%h want=%h", n, q5_data[n][47:32], exp_w[n]); end
            total++; if (q5_keep[n] !== 64'h000000000000FFFF || q5_last[n] !== 1'b1) begin bad++; $display("FAIL seq_keep%0d got=%h last=%b want=ffff,1", n, q5_keep[n], q5_last[n]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_dw256_gap();
        test_sweep();
        test_stop_backpressure();
        test_reset_mid();
        test_seqnum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
